// File: rtl/code_lock_param.sv
// Parametrised code lock: PWD_W-bit password check on confirm pulses, attempt countdown, password change, lockout.
// Optional macro CODE_LOCK_LOCKOUT_EN: timed lockout of LOCKOUT_CYC cycles; otherwise lockout holds until rst.
module code_lock_param #(
  parameter int               PWD_W       = 4,
  parameter logic [PWD_W-1:0] DEFAULT_PWD = 4'b1101,
  parameter int               MAX_TRIES   = 3,
  parameter int               LOCKOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfm_pulse,
  input  logic             chg_pulse,
  input  logic [PWD_W-1:0] sw_pwd,
  output logic [1:0]       led,
  output logic [8:0]       sega,
  output logic [8:0]       segb,
  output logic [3:0]       tries_left
);

  if (PWD_W < 1 || PWD_W > 16) begin : g_bad_pwd_w
    $error("code_lock_param: PWD_W out of range");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 9) begin : g_bad_tries
    $error("code_lock_param: MAX_TRIES out of range");
  end
  if (LOCKOUT_CYC < 1) begin : g_bad_lockout
    $error("code_lock_param: LOCKOUT_CYC must be at least 1");
  end

  localparam logic [8:0] SEG_DASH = 9'h040;
  localparam logic [8:0] SEG_C    = 9'h039;
  localparam logic [8:0] SEG_L    = 9'h038;
  localparam logic [3:0] TRIES_RST = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    UNLOCKED = 2'd1,
    CHG_WAIT = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  function automatic logic [8:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 9'h03f;
      4'd1:    seg_digit = 9'h006;
      4'd2:    seg_digit = 9'h05b;
      4'd3:    seg_digit = 9'h04f;
      4'd4:    seg_digit = 9'h066;
      4'd5:    seg_digit = 9'h06d;
      4'd6:    seg_digit = 9'h07d;
      4'd7:    seg_digit = 9'h007;
      4'd8:    seg_digit = 9'h07f;
      4'd9:    seg_digit = 9'h06f;
      default: seg_digit = SEG_DASH;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [PWD_W-1:0] pwd, pwd_nxt;
  logic [3:0]       tries_nxt;
  logic [1:0]       led_nxt;
  logic [8:0]       sega_nxt, segb_nxt;

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam int CNT_W = $clog2(LOCKOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCKOUT_CYC - 1);
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARMED;
      pwd        <= DEFAULT_PWD;
      tries_left <= TRIES_RST;
      led        <= 2'b11;
      sega       <= seg_digit(TRIES_RST);
      segb       <= seg_digit(4'd0);
`ifdef CODE_LOCK_LOCKOUT_EN
      lock_cnt   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      pwd        <= pwd_nxt;
      tries_left <= tries_nxt;
      led        <= led_nxt;
      sega       <= sega_nxt;
      segb       <= segb_nxt;
`ifdef CODE_LOCK_LOCKOUT_EN
      lock_cnt   <= lock_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    pwd_nxt   = pwd;
    tries_nxt = tries_left;
    led_nxt   = led;
    sega_nxt  = sega;
    segb_nxt  = segb;
`ifdef CODE_LOCK_LOCKOUT_EN
    lock_cnt_nxt = lock_cnt;
`endif

    case (state)
      ARMED: begin
        if (cfm_pulse) begin
          if (sw_pwd == pwd) begin
            state_nxt = UNLOCKED;
            led_nxt   = 2'b10;
            sega_nxt  = SEG_DASH;
            segb_nxt  = SEG_DASH;
          end else if (tries_left > 4'd1) begin
            tries_nxt = tries_left - 4'd1;
            led_nxt   = 2'b01;
            sega_nxt  = seg_digit(tries_left - 4'd1);
          end else begin
            state_nxt = LOCKOUT;
            tries_nxt = 4'd0;
            led_nxt   = 2'b00;
            sega_nxt  = seg_digit(4'd0);
            segb_nxt  = SEG_L;
`ifdef CODE_LOCK_LOCKOUT_EN
            lock_cnt_nxt = '0;
`endif
          end
        end
      end

      UNLOCKED: begin
        // Change request takes priority over a coincident confirm.
        if (chg_pulse) begin
          state_nxt = CHG_WAIT;
          sega_nxt  = SEG_C;
          segb_nxt  = SEG_C;
        end else if (cfm_pulse) begin
          state_nxt = ARMED;
          tries_nxt = TRIES_RST;
          led_nxt   = 2'b11;
          sega_nxt  = seg_digit(TRIES_RST);
          segb_nxt  = seg_digit(4'd0);
        end
      end

      CHG_WAIT: begin
        if (cfm_pulse) begin
          pwd_nxt   = sw_pwd;
          state_nxt = ARMED;
          tries_nxt = TRIES_RST;
          led_nxt   = 2'b11;
          sega_nxt  = seg_digit(TRIES_RST);
          segb_nxt  = seg_digit(4'd0);
        end else if (chg_pulse) begin
          state_nxt = UNLOCKED;
          led_nxt   = 2'b10;
          sega_nxt  = SEG_DASH;
          segb_nxt  = SEG_DASH;
        end
      end

      LOCKOUT: begin
`ifdef CODE_LOCK_LOCKOUT_EN
        // Counter reads k after the k-th edge in lockout; leave on edge LOCKOUT_CYC.
        if (lock_cnt == CNT_LAST) begin
          state_nxt    = ARMED;
          tries_nxt    = TRIES_RST;
          led_nxt      = 2'b11;
          sega_nxt     = seg_digit(TRIES_RST);
          segb_nxt     = seg_digit(4'd0);
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
`endif
      end

      default: state_nxt = ARMED;
    endcase
  end

endmodule

// File: tb/tb_code_lock_param.sv
// Scoreboard bench for code_lock_param: driver queues expected outputs per cycle, monitor checks them.
module tb_code_lock_param;

  localparam logic [8:0] D0 = 9'h03f, D1 = 9'h006, D2 = 9'h05b, D3 = 9'h04f;
  localparam logic [8:0] DASH = 9'h040, SC = 9'h039, SL = 9'h038;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfm_pulse = 1'b0;
  logic       chg_pulse = 1'b0;
  logic [3:0] sw_pwd = 4'h0;
  logic [1:0] led;
  logic [8:0] sega, segb;
  logic [3:0] tries_left;

  code_lock_param #(
    .PWD_W(4), .DEFAULT_PWD(4'hD), .MAX_TRIES(3), .LOCKOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .cfm_pulse(cfm_pulse), .chg_pulse(chg_pulse),
    .sw_pwd(sw_pwd), .led(led), .sega(sega), .segb(segb), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] led;
    logic [8:0] sa;
    logic [8:0] sb;
    logic [3:0] tl;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (led !== e.led || sega !== e.sa || segb !== e.sb || tries_left !== e.tl) begin
        n_fail++;
        $display("FAIL %s: got led=%b sega=%h segb=%h tries=%0d, want led=%b sega=%h segb=%h tries=%0d",
                 e.name, led, sega, segb, tries_left, e.led, e.sa, e.sb, e.tl);
      end
    end
  end

  // Apply one cycle of inputs, sampled at the next rising edge.
  task automatic drive(input logic r, input logic cfm, input logic chg, input logic [3:0] sw);
    @(posedge clk);
    #1;
    rst = r; cfm_pulse = cfm; chg_pulse = chg; sw_pwd = sw;
  endtask

  // Expected outputs after the edge that samples the most recent drive().
  task automatic expect_out(input string name, input logic [1:0] l, input logic [8:0] sa,
                            input logic [8:0] sb, input logic [3:0] tl);
    exp_t e;
    e.name = name; e.led = l; e.sa = sa; e.sb = sb; e.tl = tl; e.due = cyc + 1;
    q.push_back(e);
  endtask

  initial begin
    drive(1, 0, 0, 4'h0);  expect_out("reset",          2'b11, D3, D0, 4'd3);
    drive(1, 1, 0, 4'hD);  expect_out("pulse_in_reset", 2'b11, D3, D0, 4'd3);
    drive(0, 1, 0, 4'hD);  expect_out("unlock_default", 2'b10, DASH, DASH, 4'd3);
    drive(0, 1, 0, 4'h0);  expect_out("relock",         2'b11, D3, D0, 4'd3);

    drive(0, 1, 0, 4'h2);  expect_out("wrong1",         2'b01, D2, D0, 4'd2);
    drive(0, 1, 0, 4'h2);  expect_out("wrong2",         2'b01, D1, D0, 4'd1);
    drive(0, 1, 0, 4'h2);  expect_out("wrong3_lockout", 2'b00, D0, SL, 4'd0);

`ifdef CODE_LOCK_LOCKOUT_EN
    for (int i = 1; i < 16; i++) begin
      drive(0, 1, 0, 4'hD); expect_out("lockout_hold", 2'b00, D0, SL, 4'd0);
    end
    drive(0, 1, 0, 4'hD);  expect_out("lockout_expire", 2'b11, D3, D0, 4'd3);
    drive(0, 0, 0, 4'h0);  expect_out("armed_after",    2'b11, D3, D0, 4'd3);
`else
    for (int i = 0; i < 100; i++) begin
      drive(0, (i % 2) == 0, (i % 3) == 0, 4'hD);
      expect_out("lockout_perm", 2'b00, D0, SL, 4'd0);
    end
`endif
    drive(1, 0, 0, 4'h0);  expect_out("reset_lockout",  2'b11, D3, D0, 4'd3);

    // chg in ARMED is ignored; password stays default
    drive(0, 0, 1, 4'h5);  expect_out("chg_in_armed",   2'b11, D3, D0, 4'd3);
    drive(0, 1, 0, 4'h5);  expect_out("armed_chg_pwd",  2'b01, D2, D0, 4'd2);
    drive(0, 1, 0, 4'hD);  expect_out("unlock_keep_tl", 2'b10, DASH, DASH, 4'd2);

    // change password to 5
    drive(0, 0, 1, 4'h0);  expect_out("enter_chg",      2'b10, SC, SC, 4'd2);
    drive(0, 1, 0, 4'h5);  expect_out("chg_commit",     2'b11, D3, D0, 4'd3);
    drive(0, 1, 0, 4'hD);  expect_out("old_pwd_wrong",  2'b01, D2, D0, 4'd2);
    drive(0, 1, 0, 4'h5);  expect_out("new_pwd_ok",     2'b10, DASH, DASH, 4'd2);

    // abort, then simultaneous pulses, then reset mid-change
    drive(0, 0, 1, 4'h0);  expect_out("enter_chg2",     2'b10, SC, SC, 4'd2);
    drive(0, 0, 1, 4'h0);  expect_out("chg_abort",      2'b10, DASH, DASH, 4'd2);
    drive(0, 1, 1, 4'h9);  expect_out("both_pulses",    2'b10, SC, SC, 4'd2);
    drive(1, 0, 0, 4'h9);  expect_out("reset_in_chg",   2'b11, D3, D0, 4'd3);
    drive(0, 1, 0, 4'h5);  expect_out("pwd_reverted",   2'b01, D2, D0, 4'd2);
    drive(0, 1, 0, 4'hC);  expect_out("one_bit_off",    2'b01, D1, D0, 4'd1);
    drive(0, 1, 0, 4'hD);  expect_out("unlock_last",    2'b10, DASH, DASH, 4'd1);
    drive(0, 0, 0, 4'h0);  expect_out("idle_unlocked",  2'b10, DASH, DASH, 4'd1);

    for (int i = 0; i < 3; i++) drive(0, 0, 0, 4'h0);
    @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
